// File: rtl/bus_data_ram_responder.sv
// Data-bus responder: terminates CPU load/store requests against a
// word-organised RAM with configurable wait states, RV32I lane handling
// and error reporting for misaligned, out-of-range and unsupported accesses.
module bus_data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [2:0]  busFunc3,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [32:0] LP_SPAN = 33'd4 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic                  w_cap;
  logic                  w_enter;
  logic                  w_we;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [2:0]            w_func3;
  logic [31:0]           w_off;
  logic                  w_oor;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_word;
  logic [31:0]           w_shift;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [3:0]            w_be;
  logic [31:0]           w_wd;
  logic                  w_ram_we;

  assign w_cap   = (r_state == S_IDLE) && busReq;
  assign w_enter = (w_next == S_RESP) && (r_state != S_RESP);

  // With zero wait states the access resolves on the capture edge itself,
  // so operands come straight from the bus while idle and from the
  // request registers otherwise.
  always_comb begin
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_func3 = r_func3;
    if (r_state == S_IDLE) begin
      w_we    = busWe;
      w_addr  = busAddr;
      w_wdata = busWData;
      w_func3 = busFunc3;
    end
  end

  assign w_off  = w_addr - BASE_ADDR;
  assign w_oor  = (w_addr < BASE_ADDR) || ({1'b0, w_off} >= LP_SPAN);
  assign w_idx  = w_off[ADDR_WIDTH+1:2];
  assign w_lane = w_addr[1:0];

  // Access legality: range, alignment and supported funct3 per direction
  always_comb begin
    w_err = w_oor;
    if ((w_func3[1:0] == 2'd1) && w_addr[0])
      w_err = 1'b1;
    if ((w_func3[1:0] == 2'd2) && (w_lane != 2'd0))
      w_err = 1'b1;
    if (!w_we && ((w_func3 == 3'd3) || (w_func3 == 3'd6) || (w_func3 == 3'd7)))
      w_err = 1'b1;
    if (w_we && (w_func3 > 3'd2))
      w_err = 1'b1;
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_lane, 3'b000};
  assign w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];

  // Load lane selection and sign/zero extension
  always_comb begin
    w_load = '0;
    case (w_func3)
      3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd2:    w_load = w_word;
      3'd4:    w_load = {24'd0, w_shift[7:0]};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = '0;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    w_be = '0;
    w_wd = '0;
    case (w_func3)
      3'd0: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{w_wdata[7:0]}};
      end
      3'd1: begin
        w_be = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      3'd2: begin
        w_be = 4'b1111;
        w_wd = w_wdata;
      end
      default: begin
        w_be = '0;
        w_wd = '0;
      end
    endcase
  end

  // RAM has no reset; gating with reset keeps a held request from writing
  assign w_ram_we = w_enter && w_we && !w_err && reset;

  // Byte-enable RAM write on the edge entering RESP
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (busReq) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_func3 <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= busWe;
        r_addr  <= busAddr;
        r_wdata <= busWData;
        r_func3 <= busFunc3;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? '0 : w_load;
      end
    end
  end

  // FSM outputs
  always_comb begin
    busReady = (r_state == S_RESP);
    busErr   = (r_state == S_RESP) && r_err;
    busRData = r_rdata;
  end

endmodule

// File: tb/tb_bus_data_ram_responder.sv
// Randomized self-checking bench: two responders (1 and 0 wait states)
// compared against a byte-addressed reference model of the data region.
module tb_bus_data_ram_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SPAN = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [2:0]  f3    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];

  logic [7:0]  mm [2][SPAN];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  bus_data_ram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(reset), .busReq(req[0]), .busWe(we[0]), .busAddr(addr[0]),
    .busWData(wdata[0]), .busFunc3(f3[0]), .busRData(rdata[0]), .busReady(rdy[0]),
    .busErr(err[0]));

  bus_data_ram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .busReq(req[1]), .busWe(we[1]), .busAddr(addr[1]),
    .busWData(wdata[1]), .busFunc3(f3[1]), .busRData(rdata[1]), .busReady(rdy[1]),
    .busErr(err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory, rules applied directly
  task automatic model(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f,
                       output logic [31:0] r, output logic e);
    longint off;
    int     o;
    off = longint'(a) - longint'(BASE);
    e = (off < 0) || (off >= SPAN);
    if ((f == 3'd1 || f == 3'd5) && a[0]) e = 1'b1;
    if (f == 3'd2 && a[1:0] != 2'd0) e = 1'b1;
    if (!w && (f == 3'd3 || f == 3'd6 || f == 3'd7)) e = 1'b1;
    if (w && f > 3'd2) e = 1'b1;
    r = '0;
    if (e) return;
    o = int'(off);
    if (w) begin
      mm[d][o] = wd[7:0];
      if (f >= 3'd1) mm[d][o+1] = wd[15:8];
      if (f == 3'd2) begin
        mm[d][o+2] = wd[23:16];
        mm[d][o+3] = wd[31:24];
      end
    end else begin
      case (f)
        3'd0: r = {{24{mm[d][o][7]}}, mm[d][o]};
        3'd4: r = {24'd0, mm[d][o]};
        3'd1: r = {{16{mm[d][o+1][7]}}, mm[d][o+1], mm[d][o]};
        3'd5: r = {16'd0, mm[d][o+1], mm[d][o]};
        default: r = {mm[d][o+3], mm[d][o+2], mm[d][o+1], mm[d][o]};
      endcase
    end
  endtask

  // One transaction; called just after a rising edge with the DUT idle
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f, input bit chk_data,
                        output logic [31:0] r_obs, output logic e_obs);
    logic [31:0] r_exp;
    logic        e_exp;
    int          k;
    model(d, w, a, wd, f, r_exp, e_exp);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; f3[d] = f;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!rdy[d] && k < 20);
    chk("latency", k, (d == 0) ? 32'd2 : 32'd1);
    r_obs = rdata[d];
    e_obs = err[d];
    chk("err", {31'd0, err[d]}, {31'd0, e_exp});
    if (chk_data) chk("rdata", rdata[d], r_exp);
    @(posedge clk); #1;
    chk("ready_one_cycle", {31'd0, rdy[d]}, 32'd0);
    chk("err_idle", {31'd0, err[d]}, 32'd0);
    req[d] = 1'b0;
  endtask

  logic [31:0] ro;
  logic        eo;
  logic [31:0] a;
  logic [2:0]  f;
  logic        w;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = BASE; wdata[d] = '0; f3[d] = 3'd2;
    end
    reset = 1'b0;
    req[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, rdy[0]}, 32'd0);
      chk("rst_err", {31'd0, err[0]}, 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_ready_b", {31'd0, rdy[1]}, 32'd0);
    end
    reset = 1'b1;
    access(0, 1'b0, BASE, 32'd0, 3'd2, 1'b0, ro, eo);

    // Fill both RAMs so every later load has a defined reference value
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < SPAN / 4; i++)
        access(d, 1'b1, BASE + 32'(4 * i), $urandom, 3'd2, 1'b1, ro, eo);

    // Directed lane handling on the one-wait-state instance
    access(0, 1'b1, BASE + 32'h4, 32'hDEADBEEF, 3'd2, 1'b1, ro, eo);
    access(0, 1'b0, BASE + 32'h4, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("lw_word", ro, 32'hDEADBEEF);
    access(0, 1'b1, BASE + 32'h5, 32'h0000_0080, 3'd0, 1'b1, ro, eo);
    access(0, 1'b0, BASE + 32'h4, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("sb_merge", ro, 32'hDEAD80EF);
    access(0, 1'b0, BASE + 32'h5, 32'd0, 3'd0, 1'b1, ro, eo);
    chk("lb", ro, 32'hFFFFFF80);
    access(0, 1'b0, BASE + 32'h5, 32'd0, 3'd4, 1'b1, ro, eo);
    chk("lbu", ro, 32'h00000080);
    access(0, 1'b0, BASE + 32'h6, 32'd0, 3'd1, 1'b1, ro, eo);
    chk("lh", ro, 32'hFFFFDEAD);

    // Rejected accesses
    access(0, 1'b0, BASE + 32'h2, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("err_lw_mis", {31'd0, eo}, 32'd1);
    access(0, 1'b1, BASE + 32'h1, 32'h5555, 3'd1, 1'b1, ro, eo);
    chk("err_sh_mis", {31'd0, eo}, 32'd1);
    access(0, 1'b0, BASE + 32'h400, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("err_high", {31'd0, eo}, 32'd1);
    access(0, 1'b0, 32'h0FFF_FFFC, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("err_low", {31'd0, eo}, 32'd1);
    access(0, 1'b0, BASE + 32'h4, 32'd0, 3'd3, 1'b1, ro, eo);
    chk("err_f3", {31'd0, eo}, 32'd1);
    access(0, 1'b0, BASE, 32'd0, 3'd2, 1'b1, ro, eo);
    access(0, 1'b0, BASE + 32'h4, 32'd0, 3'd2, 1'b1, ro, eo);
    chk("no_change", ro, 32'hDEAD80EF);

    // Back-to-back word loads, zero wait states
    for (int i = 0; i < 8; i++)
      access(1, 1'b0, BASE + 32'(4 * $urandom_range(0, 255)), 32'd0, 3'd2, 1'b1, ro, eo);

    // Randomized mix on both instances
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'(SPAN) + 32'($urandom_range(0, 15));
        default: a = BASE + 32'($urandom_range(0, SPAN - 1));
      endcase
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      access(n % 2, w, a, $urandom, f, 1'b1, ro, eo);
    end

    // Reset during WAIT of a store aborts it
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = BASE + 32'h8; wdata[0] = 32'h12345678; f3[0] = 3'd2;
    @(posedge clk); #1;
    reset = 1'b0;
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", {31'd0, rdy[0]}, 32'd0);
    chk("midrst_rdata", rdata[0], 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst_quiet", {31'd0, rdy[0]}, 32'd0);
    end
    access(0, 1'b0, BASE + 32'h8, 32'd0, 3'd2, 1'b1, ro, eo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_data_ram_responder.md
Name: bus_data_ram_responder

Overview:
Bus responder that terminates the CPU datapath's data-bus requests (busAddr/busWData/busRData) with a ready handshake and a configurable number of wait states. It owns a word-organised data RAM and performs RV32I load/store width handling: byte/halfword lane selection, sign/zero extension and byte-enable writes. It reports misaligned, out-of-range and unsupported accesses as errors. It sits between the multicycle CPU's memory-access stage and the data memory region of the address map.

Parameters:
ADDR_WIDTH, 8, word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words (1 KiB at default).
BASE_ADDR, 32'h1000_0000, byte address of word 0; must be 4-byte aligned.
WAIT_STATES, 1, extra cycles between request capture and response (0..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
busReq  input  1  initiator request valid; held high until busReady is seen.
busWe  input  1  1 = store, 0 = load; stable while busReq is high.
busAddr  input  32  byte address; stable while busReq is high.
busWData  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
busFunc3  input  3  RV32I funct3: loads 0=LB,1=LH,2=LW,4=LBU,5=LHU; stores 0=SB,1=SH,2=SW.
busRData  output  32  registered load data, valid only while busReady=1.
busReady  output  1  one-cycle response strobe.
busErr  output  1  valid with busReady; 1 = access rejected.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, busReady=0, busErr=0, busRData=0. RAM contents are not cleared. Reset mid-transaction aborts the access with no write and no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with busReq=1, capture busWe/busAddr/busWData/busFunc3 into request registers and load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT: decrement the counter each cycle. On the edge where the counter equals 1, go to RESP.
- Transition into RESP (same edge): compute the error, perform the RAM write or read, and register busRData/busErr. RESP then asserts busReady=1 for exactly one cycle and returns to IDLE.
- Latency: with the request sampled at edge E0, busReady is high in the cycle after edge E0+WAIT_STATES. This is 1 cycle at WAIT_STATES=0 and 2 cycles at the default.
- busReq is ignored in WAIT and RESP. The initiator drops busReq in the cycle after busReady. A request still high in IDLE after RESP is treated as a new request. Inputs are not re-sampled after capture.
- Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2]. Lane = addr[1:0].
- Error (busErr=1, no write, busRData=0) if any of the following holds:
  - addr < BASE_ADDR, or addr - BASE_ADDR >= 4*2**ADDR_WIDTH;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - load funct3 ∈ {3,6,7};
  - store funct3 > 2.
- Loads:
  - LB/LBU select byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU select halfword addr[1]; LH sign-extends, LHU zero-extends.
  - LW returns the whole word.
- Stores write only the addressed lanes; other bytes are preserved.
  - SB: enable bit = 1<<addr[1:0], data = wdata[7:0] replicated.
  - SH: enables 0011 or 1100 by addr[1], data = wdata[15:0] replicated.
  - SW: enables 1111.
- Store response: busRData=0, busErr=0.
- Outside RESP: busReady=0 and busErr=0; busRData holds its last value.

Test Plan:
- Reset: hold reset=0 while busReq=1 at BASE_ADDR → busReady=0, busErr=0, busRData=0, no state change. Release → first response appears after nominal latency.
- Store/load word, WAIT_STATES=1: SW 32'hDEADBEEF @ 0x1000_0004, then LW @ 0x1000_0004 → busReady exactly 2 cycles after each request capture; load returns 32'hDEADBEEF, busErr=0.
- Lane handling:
  - SB 0x80 @ 0x1000_0005 → LW @ 0x1000_0004 returns 32'hDEAD80EF.
  - LB @ 0x1000_0005 returns 32'hFFFFFF80.
  - LBU returns 32'h00000080.
  - LH @ 0x1000_0006 returns 32'hFFFFDEAD.
- Errors, each giving busErr=1 with busReady and no RAM change (verified by a later read):
  - LW @ 0x1000_0002;
  - SH @ 0x1000_0001;
  - LW @ 0x1000_0400 (out of range);
  - LW @ 0x0FFF_FFFC;
  - load funct3=3.
- Zero wait states (WAIT_STATES=0): back-to-back LW with busReq dropped one cycle after each busReady → busReady in the cycle after capture every time, never on two consecutive cycles.
- Reset mid-op: assert reset during WAIT of an SW 0x12345678 @ 0x1000_0008 → no busReady, word unchanged on a later LW. A following request completes normally.
